// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES encryptor: owns the state register and round counter,
// fetches round keys from an external key-expansion unit and steps an external round datapath.
module aes_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned W          = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] block_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] block_out,
  output logic         rk_req,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [W-1:0] round_key,
  output logic [W-1:0] dp_state,
  output logic         dp_last,
  input  logic [W-1:0] dp_result
);

  localparam logic [3:0] LastRnd = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {StIdle, StKey0, StRound, StDone} st_e;

  st_e          st_q;
  logic [W-1:0] state_q;
  logic [3:0]   rnd_q;
  logic [3:0]   rnd_inc;
  logic [W-1:0] round_out;

  assign rnd_inc   = rnd_q + 4'd1;
  assign round_out = dp_result ^ round_key;
  assign dp_state  = state_q;

  // All outputs are registered alongside the state, so they are set from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= StIdle;
      state_q   <= '0;
      rnd_q     <= '0;
      block_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rk_req    <= 1'b0;
      rk_idx    <= '0;
      dp_last   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st_q)
        StIdle: begin
          if (start) begin
            state_q <= block_in;
            st_q    <= StKey0;
            busy    <= 1'b1;
            rk_req  <= 1'b1;
            rk_idx  <= '0;
            dp_last <= 1'b0;
          end
        end
        StKey0: begin
          if (rk_valid) begin
            state_q <= state_q ^ round_key;
            rnd_q   <= 4'd1;
            st_q    <= StRound;
            rk_idx  <= 4'd1;
            dp_last <= (LastRnd == 4'd1);
          end
        end
        StRound: begin
          if (rk_valid) begin
            state_q <= round_out;
            if (rnd_q < LastRnd) begin
              rnd_q   <= rnd_inc;
              rk_idx  <= rnd_inc;
              dp_last <= (rnd_inc == LastRnd);
            end else begin
              block_out <= round_out;
              st_q      <= StDone;
              busy      <= 1'b0;
              done      <= 1'b1;
              rk_req    <= 1'b0;
              rk_idx    <= '0;
              dp_last   <= 1'b0;
            end
          end
        end
        StDone: begin
          st_q <= StIdle;
        end
        default: begin
          st_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench: AES-128 round and key-schedule reference models stand in for the external
// datapath and key-expansion unit; ciphertexts are the published FIPS-197 vectors.
module tb_aes_round_ctrl;

  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] block_in;
  logic         busy;
  logic         done;
  logic [127:0] block_out;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [127:0] dp_state;
  logic         dp_last;
  logic [127:0] dp_result;
  logic [127:0] cur_key;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NUM_ROUNDS(10), .W(128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .block_in  (block_in),
    .busy      (busy),
    .done      (done),
    .block_out (block_out),
    .rk_req    (rk_req),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .round_key (round_key),
    .dp_state  (dp_state),
    .dp_last   (dp_last),
    .dp_result (dp_result)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h01;
    t = x;
    for (int i = 0; i < 7; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0]   b  [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) sr[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
        sr[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        sr[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        sr[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        sr[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sr[i];
    return o;
  endfunction

  function automatic logic [127:0] key_sched(input logic [127:0] key, input logic [3:0] idx);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    int          k;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    k = int'(idx);
    if (k > 10) return '0;
    return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  assign dp_result = aes_round(dp_state, dp_last);
  assign round_key = key_sched(cur_key, rk_idx);

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts one encryption from IDLE and returns in the done cycle (or on timeout).
  task automatic run_enc(input logic [127:0] pt, input logic [127:0] key, input int k0s,
                         input int r5s, input bit pulse_start, input bit chk_r1,
                         output int done_cyc);
    int n;
    int k0n;
    int r5n;
    int last_hi;
    int last_bad;
    k0n = 0; r5n = 0; last_hi = 0; last_bad = 0;
    cur_key  = key;
    block_in = pt;
    start    = 1'b1;
    rk_valid = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      if (rk_req && rk_idx == 4'd0 && k0n < k0s) begin
        rk_valid = 1'b0; k0n++;
      end else if (rk_req && rk_idx == 4'd5 && r5n < r5s) begin
        rk_valid = 1'b0; r5n++;
      end else begin
        rk_valid = 1'b1;
      end
      if (dp_last) last_hi++;
      if (dp_last != (rk_req && rk_idx == 4'd10)) last_bad++;
      if (chk_r1 && n == 2) check("round1_state", dp_state, R1B);
      if (chk_r1 && n == 1) check("key0_rk_req", {rk_req, rk_idx}, 5'b1_0000);
      if (pulse_start) begin
        start    = (n == 5);
        block_in = PtC;
      end
      tick();
      n++;
    end
    start    = 1'b0;
    rk_valid = 1'b0;
    check("done_seen", done, 1'b1);
    check("latency", n, 12 + k0s + r5s);
    check("dp_last_cycles", last_hi, 1);
    check("dp_last_idx", last_bad, 0);
    check("busy_in_done", busy, 1'b0);
    done_cyc = cyc;
  endtask

  initial begin
    int d1;
    int d2;
    int n_done;
    rst_n    = 1'b0;
    start    = 1'b1;
    rk_valid = 1'b1;
    block_in = PtC;
    cur_key  = KeyB;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rk", {rk_req, rk_idx, dp_last}, '0);
    check("rst_state", dp_state, '0);
    check("rst_block_out", block_out, '0);
    start    = 1'b0;
    rk_valid = 1'b0;
    rst_n    = 1'b1;
    tick();

    // Plain FIPS-197 run, keys always ready
    run_enc(PtB, KeyB, 0, 0, 1'b0, 1'b1, d1);
    check("ct_fips", block_out, CtB);
    tick();
    check("idle_done", done, 1'b0);
    check("idle_busy", busy, 1'b0);

    // Key stalls in KEY0 and ROUND5
    run_enc(PtB, KeyB, 3, 2, 1'b0, 1'b0, d1);
    check("ct_stall", block_out, CtB);
    tick();

    // Starts while busy and in DONE are dropped
    run_enc(PtB, KeyB, 0, 0, 1'b1, 1'b0, d1);
    check("ct_ignored", block_out, CtB);
    block_in = PtC;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_busy", busy, 1'b0);
    check("start_in_done_rkreq", rk_req, 1'b0);
    tick();
    check("start_in_done_busy2", busy, 1'b0);
    check("block_out_held", block_out, CtB);
    run_enc(PtC, KeyC, 0, 0, 1'b0, 1'b0, d1);
    check("ct_fips_c1", block_out, CtC);
    tick();

    // Reset mid-operation
    cur_key  = KeyB;
    block_in = PtB;
    start    = 1'b1;
    rk_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_rk", {rk_req, rk_idx, dp_last}, '0);
    check("abort_state", dp_state, '0);
    check("abort_block_out", block_out, '0);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (20) begin
      if (done || busy) n_done++;
      tick();
    end
    check("abort_quiet", n_done, 0);
    run_enc(PtB, KeyB, 0, 0, 1'b0, 1'b1, d1);
    check("ct_after_abort", block_out, CtB);
    tick();

    // Back-to-back, second start in the cycle after done
    run_enc(PtC, KeyC, 0, 0, 1'b0, 1'b0, d1);
    check("ct_b2b_first", block_out, CtC);
    tick();
    run_enc(PtB, KeyB, 0, 0, 1'b0, 1'b0, d2);
    check("ct_b2b_second", block_out, CtB);
    check("b2b_gap", d2 - d1, 13);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, giving the number of cipher rounds (AES-128).
REQ-002 The block SHALL have parameter W, default 128, giving the state/key width in bits.
REQ-003 Port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  in  1  reset, synchronous and active-low.
REQ-005 Port start  in  1  request to encrypt block_in; sampled only in IDLE.
REQ-006 Port block_in  in  W  plaintext, captured on the accepted start.
REQ-007 Port busy  out  1  high in KEY0 and ROUND states.
REQ-008 Port done  out  1  one-cycle pulse; block_out valid from this cycle on.
REQ-009 Port block_out  out  W  ciphertext; held until the next done.
REQ-010 Port rk_req  out  1  round-key request to the key-expansion unit.
REQ-011 Port rk_idx  out  4  index of the requested round key, 0..NUM_ROUNDS.
REQ-012 Port rk_valid  in  1  round_key valid; consumed only when rk_req=1.
REQ-013 Port round_key  in  W  round key for rk_idx.
REQ-014 Port dp_state  out  W  current state register, fed to the external round datapath (SubBytes, shiftRows, MixColumns).
REQ-015 Port dp_last  out  1  high in the final round; the datapath bypasses MixColumns.
REQ-016 Port dp_result  in  W  combinational datapath result for dp_state, excluding AddRoundKey.

Function
REQ-017 The FSM SHALL have states IDLE, KEY0, ROUND and DONE, a W-bit state register and a 4-bit round counter rnd.
REQ-018 In IDLE with start=1, the block SHALL capture block_in into the state register and go to KEY0; start=0 SHALL hold IDLE.
REQ-019 In KEY0 the block SHALL drive rk_req=1 and rk_idx=0.
REQ-020 On rk_valid=1 in KEY0, the block SHALL load state <= state XOR round_key, set rnd=1 and go to ROUND.
REQ-021 In ROUND the block SHALL drive rk_req=1, rk_idx=rnd, dp_state=state and dp_last=(rnd==NUM_ROUNDS).
REQ-022 On rk_valid=1 in ROUND, the block SHALL load state <= dp_result XOR round_key.
REQ-023 On that same edge: if rnd<NUM_ROUNDS, rnd SHALL increment; otherwise block_out SHALL load the same value and the FSM SHALL go to DONE.
REQ-024 rk_valid=0 in KEY0 or ROUND SHALL stall with state, rnd and outputs unchanged; each stall cycle adds exactly one cycle of latency.
REQ-025 rk_valid while rk_req=0 SHALL be ignored.
REQ-026 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-027 start during KEY0, ROUND or DONE SHALL be ignored and not queued.
REQ-028 With rk_valid held high, if start is sampled in cycle N, then done SHALL be high in cycle N+12 only, with ROUND1..ROUND10 in cycles N+2..N+11.
REQ-029 Outside KEY0/ROUND: rk_req=0, dp_last=0, rk_idx=0.
REQ-030 dp_state SHALL always equal the state register.
REQ-031 rnd SHALL never exceed NUM_ROUNDS and SHALL never wrap.
REQ-032 block_out SHALL change only on the edge entering DONE.

Reset
REQ-033 While rst_n=0 at a rising edge, the FSM SHALL go to IDLE, clearing state, rnd and block_out to 0 and driving busy=0, done=0, rk_req=0, rk_idx=0 and dp_last=0.
REQ-034 Reset asserted mid-operation (KEY0, ROUND or DONE) SHALL abort the operation without a done pulse; the first start after reset release SHALL begin a fresh encryption.
REQ-035 Reset SHALL take priority over start and rk_valid in the same cycle.

Verification
REQ-036 FIPS-197 B: block_in=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, reference round model, rk_valid=1 -> state=193de3bea0f4e22b9ac68d2ae9f84808 in cycle N+2; block_out=3925841d02dc09fbdc118597196a0b32 with done in cycle N+12.
REQ-037 Same vector, rk_valid low for 3 cycles in KEY0 and 2 cycles in ROUND5 -> done in cycle N+17, same ciphertext, and dp_last high only while rk_idx=10.
REQ-038 start pulsed in cycles N+5 and N+12 with a different block_in -> ignored; block_out unchanged; the next start in IDLE encrypts the new block.
REQ-039 rst_n low in cycle N+7 for one cycle -> all outputs 0 the next cycle; no done; a subsequent FIPS run gives the correct ciphertext.
REQ-040 Two back-to-back encryptions, start raised in the cycle after done -> second done exactly 13 cycles after the first; each block_out is correct.
